// File: rtl/carrier_sense_detector_pkg.sv
// Shared carrier-sense definitions: FSM state encodings and default thresholds,
// also used by the backoff generator status logic.
package carrier_sense_detector_pkg;

  typedef logic [1:0] cs_state_t;

  localparam logic [1:0] ST_WARMUP  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [31:0] DEF_THRESHOLD_ON  = 32'd5000;
  localparam logic [31:0] DEF_THRESHOLD_OFF = 32'd2000;

endpackage

// File: rtl/carrier_sense_detector_power_window_avg.sv
// S1+S2 of the carrier-sense pipeline: sample power |x|^2 and a 2^LOG2_WIN-sample
// moving average built from a circular buffer and a running sum.
module power_window_avg #(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_WIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       sample_en,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  output logic [31:0]                power_avg,
  output logic                       avg_valid,
  output logic                       window_full
);
  import carrier_sense_detector_pkg::*;

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = 32 + LOG2_WIN;
  localparam logic [LOG2_WIN:0]   FILL_MAX = WIN[LOG2_WIN:0];
  localparam logic [LOG2_WIN:0]   FILL_ONE = {{LOG2_WIN{1'b0}}, 1'b1};
  localparam logic [LOG2_WIN-1:0] PTR_ONE  = {{(LOG2_WIN-1){1'b0}}, 1'b1};

  logic signed [2*SAMPLE_W-1:0] ii, qq;
  logic [31:0]         p_q;
  logic                p_valid;
  logic [31:0]         win_mem [WIN];
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [LOG2_WIN:0]   fill_q;
  logic [SUM_W-1:0]    sum_q, sum_next;
  logic [31:0]         oldest;

  assign ii = i_in * i_in;
  assign qq = q_in * q_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q     <= '0;
      p_valid <= 1'b0;
    end else if (flush) begin
      p_q     <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= sample_en;
      if (sample_en) p_q <= 32'($unsigned(ii)) + 32'($unsigned(qq));
    end
  end

  assign window_full = (fill_q == FILL_MAX);
  // The oldest entry only leaves the sum once the window has been filled once.
  assign oldest   = window_full ? win_mem[wr_ptr] : 32'd0;
  assign sum_next = sum_q + SUM_W'(p_q) - SUM_W'(oldest);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q     <= '0;
      fill_q    <= '0;
      wr_ptr    <= '0;
      power_avg <= '0;
      avg_valid <= 1'b0;
    end else if (flush) begin
      sum_q     <= '0;
      fill_q    <= '0;
      wr_ptr    <= '0;
      power_avg <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= p_valid;
      if (p_valid) begin
        sum_q     <= sum_next;
        power_avg <= sum_next[SUM_W-1:LOG2_WIN];
        wr_ptr    <= wr_ptr + PTR_ONE;
        if (!window_full) fill_q <= fill_q + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (p_valid && !flush) win_mem[wr_ptr] <= p_q;
  end

endmodule

// File: rtl/carrier_sense_detector.sv
// Energy-based carrier sense: windowed average power judged against on/off
// thresholds with a release hold-off; result feeds the backoff generator.
module carrier_sense_detector #(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_WIN = 4,
  parameter int HOLD_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strobe,
  input  logic                       run_rx,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  input  logic [31:0]                threshold_on,
  input  logic [31:0]                threshold_off,
  input  logic [HOLD_W-1:0]          min_hold,
  output logic                       carrier_present,
  output logic [31:0]                power_avg,
  output logic [1:0]                 fsm_state
);
  import carrier_sense_detector_pkg::*;

  // Handshake: a sample is consumed on every clock where strobe && run_rx; there is
  // no back-pressure. run_rx low flushes the whole pipeline and wins over strobe.
  logic sample_en, flush, avg_valid, window_full;
  assign sample_en = strobe & run_rx;
  assign flush     = ~run_rx;

  power_window_avg #(
    .SAMPLE_W(SAMPLE_W),
    .LOG2_WIN(LOG2_WIN)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .sample_en  (sample_en),
    .i_in       (i_in),
    .q_in       (q_in),
    .power_avg  (power_avg),
    .avg_valid  (avg_valid),
    .window_full(window_full)
  );

  cs_state_t         state, state_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [HOLD_W:0]   hold_inc, hold_limit;

  assign hold_inc   = {1'b0, hold} + {{HOLD_W{1'b0}}, 1'b1};
  assign hold_limit = (min_hold == '0) ? {{HOLD_W{1'b0}}, 1'b1} : {1'b0, min_hold};

  always_comb begin
    state_n = state;
    hold_n  = hold;
    case (state)
      ST_WARMUP: begin
        if (window_full) begin
          if (power_avg >= threshold_on) begin
            state_n = ST_PRESENT;
            hold_n  = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (power_avg >= threshold_on) begin
          state_n = ST_PRESENT;
          hold_n  = '0;
        end
      end
      ST_PRESENT: begin
        if (power_avg < threshold_off) begin
          // Saturate rather than wrap; a saturated count always exceeds the limit.
          hold_n = hold_inc[HOLD_W] ? hold : hold_inc[HOLD_W-1:0];
          if (hold_inc >= hold_limit) state_n = ST_IDLE;
        end else begin
          hold_n = '0;
        end
      end
      default: state_n = ST_WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_WARMUP;
      hold            <= '0;
      carrier_present <= 1'b0;
    end else if (flush) begin
      state           <= ST_WARMUP;
      hold            <= '0;
      carrier_present <= 1'b0;
    end else if (avg_valid) begin
      state           <= state_n;
      hold            <= hold_n;
      carrier_present <= (state_n == ST_PRESENT);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_carrier_sense_detector.sv
// Scoreboard bench for carrier_sense_detector: directed sample sequences with a
// reference window/FSM model feeding expected queues, checked by a monitor.
module tb_carrier_sense_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               strobe = 1'b0;
  logic               run_rx = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic [31:0]        threshold_on = 32'd5000;
  logic [31:0]        threshold_off = 32'd2000;
  logic [15:0]        min_hold = 16'd4;
  logic               carrier_present;
  logic [31:0]        power_avg;
  logic [1:0]         fsm_state;

  carrier_sense_detector dut (
    .clk            (clk),
    .rst            (rst),
    .strobe         (strobe),
    .run_rx         (run_rx),
    .i_in           (i_in),
    .q_in           (q_in),
    .threshold_on   (threshold_on),
    .threshold_off  (threshold_off),
    .min_hold       (min_hold),
    .carrier_present(carrier_present),
    .power_avg      (power_avg),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_avg_q[$];
  logic [0:0]  exp_car_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model of the window and the carrier FSM (0=WARMUP 1=IDLE 2=PRESENT)
  longint m_win[16];
  longint m_sum;
  int     m_fill, m_ptr, m_state, m_hold;

  task automatic model_reset();
    m_sum = 0; m_fill = 0; m_ptr = 0; m_state = 0; m_hold = 0;
  endtask

  task automatic model_sample(input longint i, input longint q);
    longint p, avg;
    int lim, h;
    p = i * i + q * q;
    if (m_fill == 16) m_sum = m_sum - m_win[m_ptr];
    m_sum = m_sum + p;
    m_win[m_ptr] = p;
    m_ptr = (m_ptr + 1) % 16;
    if (m_fill < 16) m_fill++;
    avg = m_sum >> 4;
    if (m_state == 0 && m_fill == 16) m_state = 1;
    if (m_state == 1) begin
      if (avg >= longint'(threshold_on)) begin m_state = 2; m_hold = 0; end
    end else if (m_state == 2) begin
      if (avg < longint'(threshold_off)) begin
        lim = (min_hold == 0) ? 1 : int'(min_hold);
        h = m_hold + 1;
        if (h >= lim) m_state = 1;
        m_hold = (h > 65535) ? 65535 : h;
      end else begin
        m_hold = 0;
      end
    end
    exp_avg_q.push_back(32'(avg));
    exp_car_q.push_back(m_state == 2);
  endtask

  // Tracks when each accepted sample reaches power_avg (d2) and carrier_present (d3)
  logic d1, d2, d3;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else if (!run_rx) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else begin
      d1 <= strobe; d2 <= d1; d3 <= d2;
    end
  end

  always @(negedge clk) begin
    if (rst && d2) begin
      if (exp_avg_q.size() == 0) check("avg_queue_underflow", 32'd1, 32'd0);
      else check("power_avg", power_avg, exp_avg_q.pop_front());
    end
    if (rst && d3) begin
      if (exp_car_q.size() == 0) check("car_queue_underflow", 32'd1, 32'd0);
      else check("carrier_present", {31'd0, carrier_present}, {31'd0, exp_car_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q);
    @(posedge clk); #1;
    strobe = 1'b1; i_in = i; q_in = q;
    if (run_rx) model_sample(longint'(i), longint'(q));
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic send_n(input int n, input logic signed [15:0] i, input logic signed [15:0] q);
    for (int k = 0; k < n; k++) send(i, q);
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drop_inflight();
    exp_avg_q.delete();
    exp_car_q.delete();
    model_reset();
  endtask

  task automatic flush_run();
    run_rx = 1'b0;
    @(posedge clk); #1;
    drop_inflight();
    run_rx = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_carrier", {31'd0, carrier_present}, 32'd0);
    check("reset_power_avg", power_avg, 32'd0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b1;
    run_rx = 1'b1;

    // 1: warm-up with p=10000, carrier rises exactly 3 cycles after 16th strobe
    send_n(15, 16'sd100, 16'sd0);
    settle();
    check("t1_warmup_carrier", {31'd0, carrier_present}, 32'd0);
    send(16'sd100, 16'sd0);
    @(negedge clk);
    check("t1_lat1_carrier", {31'd0, carrier_present}, 32'd0);
    @(negedge clk);
    check("t1_lat2_carrier", {31'd0, carrier_present}, 32'd0);
    check("t1_avg", power_avg, 32'd10000);
    @(negedge clk);
    check("t1_lat3_carrier", {31'd0, carrier_present}, 32'd1);
    settle();

    // 2: zeros, min_hold=4: low from sample 13 (1875), release after sample 16
    min_hold = 16'd4;
    send_n(15, 16'sd0, 16'sd0);
    settle();
    check("t2_hold_carrier", {31'd0, carrier_present}, 32'd1);
    send(16'sd0, 16'sd0);
    settle();
    check("t2_release_carrier", {31'd0, carrier_present}, 32'd0);
    check("t2_avg", power_avg, 32'd0);

    // 3: hysteresis, avg settles at (2500+3600)/2 = 3050
    send_n(16, 16'sd100, 16'sd0);
    for (int k = 0; k < 12; k++) begin
      send(16'sd50, 16'sd0);
      send(16'sd60, 16'sd0);
    end
    settle();
    check("t3_present_carrier", {31'd0, carrier_present}, 32'd1);
    check("t3_avg", power_avg, 32'd3050);
    threshold_off = 32'd4000;
    min_hold = 16'd1;
    send(16'sd50, 16'sd0);
    settle();
    check("t3_to_idle", {31'd0, carrier_present}, 32'd0);
    threshold_off = 32'd2000;
    for (int k = 0; k < 8; k++) begin
      send(16'sd60, 16'sd0);
      send(16'sd50, 16'sd0);
    end
    settle();
    check("t3_idle_carrier", {31'd0, carrier_present}, 32'd0);

    // 4: full-scale samples, p = 2^31 per sample
    flush_run();
    send_n(16, -16'sd32768, -16'sd32768);
    settle();
    check("t4_avg_fullscale", power_avg, 32'h8000_0000);
    check("t4_carrier", {31'd0, carrier_present}, 32'd1);

    // 5: run_rx dropped one cycle after a strobe while PRESENT
    send(16'sd100, 16'sd0);
    run_rx = 1'b0;
    @(posedge clk); #1;
    check("t5_flush_carrier", {31'd0, carrier_present}, 32'd0);
    check("t5_flush_avg", power_avg, 32'd0);
    check("t5_flush_state", {30'd0, fsm_state}, 32'd0);
    drop_inflight();
    run_rx = 1'b1;
    send_n(15, 16'sd100, 16'sd0);
    settle();
    check("t5_rewarm_carrier", {31'd0, carrier_present}, 32'd0);
    send(16'sd100, 16'sd0);
    settle();
    check("t5_reassert_carrier", {31'd0, carrier_present}, 32'd1);

    // 6: async reset between edges, then min_hold=0 behaves as 1
    send_n(8, 16'sd0, 16'sd0);
    settle();
    check("t6_pre_reset_avg", power_avg, 32'd5000);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("t6_async_carrier", {31'd0, carrier_present}, 32'd0);
    check("t6_async_avg", power_avg, 32'd0);
    drop_inflight();
    @(posedge clk); #1;
    rst = 1'b1;
    min_hold = 16'd0;
    send_n(16, 16'sd100, 16'sd0);
    send_n(12, 16'sd0, 16'sd0);
    settle();
    check("t6_avg_2500", power_avg, 32'd2500);
    check("t6_still_present", {31'd0, carrier_present}, 32'd1);
    send(16'sd0, 16'sd0);
    settle();
    check("t6_avg_1875", power_avg, 32'd1875);
    check("t6_release_min_hold0", {31'd0, carrier_present}, 32'd0);

    check("drain_avg_queue", 32'(exp_avg_q.size()), 32'd0);
    check("drain_car_queue", 32'(exp_car_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
